alu_op_issue: RTL
=================

// Module: alu_op_issue
// PURPOSE
//  Issue/retire stage wrapped around the 4-bit combinational alu. Queues operation
//  commands, drives the alu operand/opcode inputs from registers, captures R and
//  zero/carry/sign one cycle later, and presents them on a valid/ready result port.
//  Holds an accumulator so a command can use the previous result as operand A.
// PARAMETERS
//  WIDTH  4  operand/result width; fixed to alu width, not to be overridden
//  DEPTH  4  command FIFO entries; power of two
//  PTR_W  2  log2(DEPTH)
// PORTS
//  clk        in   1      single clock, rising edge
//  reset      in   1      synchronous, active-high
//  cmd_valid  in   1      command offered
//  cmd_ready  out  1      FIFO can accept (= !full)
//  cmd_a      in   WIDTH  operand A (ignored when cmd_acc=1)
//  cmd_b      in   WIDTH  operand B
//  cmd_op     in   2      ALUOp value passed to alu
//  cmd_l      in   1      L value passed to alu
//  cmd_acc    in   1      1: A operand = accumulator
//  alu_a      out  WIDTH  to alu A (registered)
//  alu_b      out  WIDTH  to alu B (registered)
//  alu_op     out  2      to alu ALUOp (registered)
//  alu_l      out  1      to alu L (registered)
//  alu_r      in   WIDTH  alu R
//  alu_zero   in   1      alu zero
//  alu_carry  in   1      alu carry
//  alu_sign   in   1      alu sign
//  res_valid  out  1      result available
//  res_ready  in   1      consumer takes result
//  res_r      out  WIDTH  captured R
//  res_zero   out  1      captured zero
//  res_carry  out  1      captured carry (verbatim, also for L=1)
//  res_sign   out  1      captured sign
//  acc        out  WIDTH  accumulator (last captured R)
//  busy       out  1      state!=IDLE or FIFO non-empty
// BEHAVIOUR
//  Reset (sync, high): FIFO empty, state IDLE, every output register 0, so
//   alu_*=0, res_*=0, res_valid=0, acc=0; cmd_ready=1 on the first cycle after reset.
//  Push: cmd_valid&&cmd_ready. cmd_ready=!full from count reg; a push to a full
//   FIFO is refused even if a pop happens in the same cycle. Simultaneous push+pop
//   when not full: count unchanged, pointers both advance mod DEPTH.
//  FSM IDLE -> DRIVE -> HOLD -> IDLE:
//   IDLE: if FIFO non-empty: pop head; alu_a<=cmd_acc?acc:cmd_a; alu_b/op/l loaded;
//    go DRIVE. Otherwise stay; alu_* hold their last values.
//   DRIVE: one cycle of stable alu inputs; at end: res_r<=alu_r, flags<=alu flags,
//    acc<=alu_r, res_valid<=1; go HOLD.
//   HOLD: res_* stable while res_valid=1; on res_ready: res_valid<=0, go IDLE.
//  Latency: command accepted at edge t0 into an empty FIFO, idle FSM ->
//   popped at t1, res_valid=1 after t2. Peak throughput: 1 result / 3 cycles.
//  Results retire strictly in command order; none dropped or duplicated.
//  Accumulator forwarding: pop happens only after the previous result is
//   captured, so cmd_acc always sees the immediately preceding result.
//  Capacity: DEPTH queued + 1 in flight before cmd_ready drops.
//  Reset mid-operation: in-flight and queued commands are discarded; no
//   res_valid is produced for them.
// TESTING (bench alu model: L=0 op00 A+B, op01 A-B; L=1 op00 AND, 01 OR, 10 XOR, 11 NOT A)
//  Reset: hold reset 2 cycles -> cmd_ready=1, res_valid=0, acc=0, alu_a/b/op/l=0, busy=0.
//  Add: push a=3,b=5,op=00,l=0 -> res_valid 2 cycles later, res_r=8, zero=0, carry=0, sign=1, acc=8.
//  Wrap: push a=9,b=7 add -> res_r=0, zero=1, carry=1, sign=0.
//  Chain: push {a=1,b=2,add,acc=0},{b=3,add,acc=1} -> results 3 then 6 in order; acc=6.
//  Backpressure: res_ready=0, push 6 back-to-back -> 5 accepted, then cmd_ready=0;
//   raise res_ready -> 5 results in push order, cmd_ready returns to 1.
//  Reset in DRIVE with 2 queued -> next cycle res_valid=0, busy=0, acc=0; no results emitted.

Source files
------------

// File: rtl/alu_op_issue.sv
// Issue/retire stage around the 4-bit combinational alu: command FIFO, registered
// alu inputs, one-cycle result capture, valid/ready result port and an accumulator.
module alu_op_issue #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    input  logic [1:0]       cmd_op,
    input  logic             cmd_l,
    input  logic             cmd_acc,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [1:0]       alu_op,
    output logic             alu_l,
    input  logic [WIDTH-1:0] alu_r,
    input  logic             alu_zero,
    input  logic             alu_carry,
    input  logic             alu_sign,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_r,
    output logic             res_zero,
    output logic             res_carry,
    output logic             res_sign,
    output logic [WIDTH-1:0] acc,
    output logic             busy
);

    // Entry layout: {acc_sel, l, op[1:0], b, a}
    localparam int ENT_W = 2 * WIDTH + 4;

    typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

    state_t             state, state_nxt;
    logic [ENT_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    logic               push, pop;
    logic [ENT_W-1:0]   head;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot.
    assign cmd_ready = (count != (PTR_W + 1)'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign head      = mem[rd_ptr];
    assign busy      = (state != IDLE) || (count != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr] <= {cmd_acc, cmd_l, cmd_op, cmd_b, cmd_a};
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    pop       = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE:   state_nxt = HOLD;
            HOLD:    if (res_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Pop only happens in IDLE, after the previous capture, so acc is always current.
    always_ff @(posedge clk) begin
        if (reset) begin
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            alu_l     <= 1'b0;
            res_valid <= 1'b0;
            res_r     <= '0;
            res_zero  <= 1'b0;
            res_carry <= 1'b0;
            res_sign  <= 1'b0;
            acc       <= '0;
        end else begin
            if (pop) begin
                alu_a  <= head[ENT_W-1] ? acc : head[WIDTH-1:0];
                alu_b  <= head[2*WIDTH-1:WIDTH];
                alu_op <= head[2*WIDTH+1:2*WIDTH];
                alu_l  <= head[2*WIDTH+2];
            end
            if (state == DRIVE) begin
                res_r     <= alu_r;
                res_zero  <= alu_zero;
                res_carry <= alu_carry;
                res_sign  <= alu_sign;
                acc       <= alu_r;
                res_valid <= 1'b1;
            end
            if (state == HOLD && res_ready) res_valid <= 1'b0;
        end
    end

endmodule
